eth_mmio_ring: RTL and testbench
================================

// Module: eth_mmio_ring
// PURPOSE
// MMIO front-end between CPU system bus and eth MAC/UDP core; multi-slot RX ring, TX buffer with busy/done handshake, IRQ.
// RX frames arrive from the core as a byte stream into RX_SLOTS buffers; CPU reads the head slot through a window, then pops it.
// TX frames are staged in a buffer that the core reads after a start pulse; completion is signalled back via i_tx_done.
// PARAMETERS
// BASE_ADDR   32'h1000_0000  base of the 16 KiB register/window region
// SLOT_BYTES  1024           bytes per RX slot and TX buffer size; power of 2, <=4096
// RX_SLOTS    4              RX ring depth; power of 2, 2..16
// PORTS
// i_clk           in   1      system clock
// i_rstn          in   1      synchronous reset, active-low
// i_we / i_re     in   1      CPU write / read strobe
// i_addr          in   32     CPU byte address
// i_data          in   32     CPU write data
// i_mem_size      in   2      00 word, 01 half, 10 byte; 11 = no-op
// o_data          out  32     CPU read data, combinational from i_addr/i_mem_size
// o_irq           out  1      level interrupt
// i_rx_valid      in   1      RX byte valid (one byte per cycle)
// i_rx_data       in   8      RX payload byte
// i_rx_last       in   1      qualifies last byte of frame (with i_rx_valid)
// i_rx_err        in   1      sampled with i_rx_last; 1 = discard frame
// i_rx_src_port   in   16     UDP src port, sampled on last
// i_rx_dest_port  in   16     UDP dest port, sampled on last
// o_tx_start      out  1      one-cycle start pulse
// o_tx_length     out  16     TX payload length, stable while busy
// i_tx_rd_addr    in   $clog2(SLOT_BYTES)  core read address into TX buffer
// o_tx_rd_data    out  8      TX byte, registered, 1-cycle latency
// i_tx_done       in   1      core finished sending
// BEHAVIOUR
// Map (offset from BASE_ADDR): 0x00 CTRL rw {irq_en[1],rx_en[0]}; 0x04 STATUS {tx_done[4] W1C, ovf[3] W1C, tx_busy[2], full[1], nonempty[0]}
//  0x08 RX_COUNT ro; 0x0C RX_LEN ro {trunc[16],len[15:0]} of head; 0x10 RX_PORTS ro {src[31:16],dest[15:0]}
//  0x14 RX_POP wo (any write); 0x18 TX_LEN rw [15:0]; 0x1C TX_TRIGGER wo (bit0); 0x20 DROP_CNT ro 16b saturating
//  0x1000+n RX head-slot window; 0x2000+n TX buffer window (rw). Unmapped/out-of-window reads 0, writes ignored.
// Window accesses little-endian; half/byte reads zero-extended; bytes past SLOT_BYTES in a multi-byte access read 0 / drop.
// Reset: CTRL, STATUS, counts, pointers, TX_LEN, DROP_CNT = 0; o_tx_start=0, o_irq=0, o_tx_rd_data=0; buffer contents undefined.
// RX FSM IDLE/RECV/DROP. IDLE+valid: rx_en && count<RX_SLOTS -> RECV writing byte 0 of tail slot; else DROP, ovf=1, DROP_CNT++.
//  RECV: each byte written at wr_idx, wr_idx++; bytes beyond SLOT_BYTES discarded, trunc=1, len capped at SLOT_BYTES.
//  last && !err: commit len/ports/trunc, tail++ (mod RX_SLOTS), count++ next cycle -> IDLE. last && err: no commit, -> IDLE.
//  DROP: discard until last -> IDLE. A 1-byte frame (valid&last in IDLE) commits directly.
// Pop: if count>0 head++, count--; pop on empty ignored. Commit+pop same cycle: count unchanged, both pointers advance.
// rx_en cleared mid-frame: current frame completes normally; affects only next frame start.
// TX FSM IDLE/BUSY. TRIGGER write bit0=1 in IDLE with TX_LEN!=0: o_tx_start=1 next cycle, -> BUSY, tx_busy=1.
//  Trigger while BUSY or TX_LEN==0 ignored. BUSY+i_tx_done: -> IDLE, tx_done=1. TX_LEN/TX-window writes ignored while BUSY.
// CPU W1C and hardware set same cycle: set wins. o_irq = irq_en & (nonempty | tx_done | ovf), registered.
// DROP_CNT saturates at 16'hFFFF. Reset is synchronous; mid-frame reset discards the frame, aborts TX (no done).
// TESTING
// Write 60-byte frame (bytes 0..59) with ports 1234/80 -> RX_COUNT=1, RX_LEN=60, RX_PORTS=0x04D2_0050, word @0x1000=0x03020100.
// Fill 4 slots, send 5th frame -> 5th dropped, ovf=1, DROP_CNT=1; pop once, 6th frame accepted into freed slot (tail wrap).
// 1100-byte frame with SLOT_BYTES=1024 -> RX_LEN=0x1_0400 (trunc), last window byte=byte 1023; err-on-last frame -> count unchanged.
// Pop on same cycle as commit with count=2 -> count stays 2, head and tail both advance; pop on empty -> no change.
// TX_LEN=64, trigger -> o_tx_start one cycle, o_tx_length=64, second trigger ignored; i_tx_done -> tx_done=1, o_irq=1 if irq_en.
// Assert i_rstn=0 mid-RX and mid-TX -> all status 0, o_tx_start=0, next frame lands in slot 0.

Source files
------------

// File: rtl/eth_mmio_ring.sv
// MMIO front-end for an Ethernet MAC/UDP core: CPU register map, multi-slot RX ring with a
// read window on the head slot, and a TX staging buffer with start/done handshake.
module eth_mmio_ring #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned SLOT_BYTES = 1024,
  parameter int unsigned RX_SLOTS   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_we,
  input  logic                          i_re,
  input  logic [31:0]                   i_addr,
  input  logic [31:0]                   i_data,
  input  logic [1:0]                    i_mem_size,
  output logic [31:0]                   o_data,
  output logic                          o_irq,
  input  logic                          i_rx_valid,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_last,
  input  logic                          i_rx_err,
  input  logic [15:0]                   i_rx_src_port,
  input  logic [15:0]                   i_rx_dest_port,
  output logic                          o_tx_start,
  output logic [15:0]                   o_tx_length,
  input  logic [$clog2(SLOT_BYTES)-1:0] i_tx_rd_addr,
  output logic [7:0]                    o_tx_rd_data,
  input  logic                          i_tx_done
);
  localparam int unsigned AW = $clog2(SLOT_BYTES);
  localparam int unsigned SW = $clog2(RX_SLOTS);
  localparam logic [SW:0] SlotsFull = (SW+1)'(RX_SLOTS);
  localparam logic [AW:0] SlotCap   = (AW+1)'(SLOT_BYTES);
  localparam logic [12:0] WinCap    = 13'(SLOT_BYTES);

  typedef enum logic [1:0] {RxIdle, RxRecv, RxDrop} rx_state_e;
  typedef enum logic {TxIdle, TxBusy} tx_state_e;

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;
  logic [AW:0] wr_idx_q, wr_idx_d;
  logic [SW-1:0] rx_head_q, rx_head_d, rx_tail_q, rx_tail_d;
  logic [SW:0] rx_count_q, rx_count_d;
  logic rx_en_q, rx_en_d, irq_en_q, irq_en_d, ovf_q, ovf_d, tx_done_q, tx_done_d;
  logic tx_start_q, tx_start_d, irq_q, irq_d;
  logic [15:0] tx_len_q, tx_len_d, drop_cnt_q, drop_cnt_d;
  logic [15:0] rx_len_q [RX_SLOTS];
  logic        rx_trunc_q [RX_SLOTS];
  logic [15:0] rx_src_q [RX_SLOTS];
  logic [15:0] rx_dest_q [RX_SLOTS];
  logic [7:0]  rx_mem [RX_SLOTS*SLOT_BYTES];
  logic [7:0]  tx_mem [SLOT_BYTES];
  logic [7:0]  tx_rd_data_q;

  logic unused_re;
  assign unused_re = i_re;

  // Address decode shared by the read and write paths.
  logic [13:0] off;
  logic [9:0]  reg_word;
  logic        in_region, reg_sel, rxw_sel, txw_sel, wr;
  logic [3:0]  byte_en, win_ok;
  logic [31:0] size_mask;
  logic [12:0] win_idx [4];

  always_comb begin
    off       = i_addr[13:0];
    reg_word  = off[11:2];
    in_region = (i_addr[31:14] == BASE_ADDR[31:14]);
    reg_sel   = in_region && (off[13:12] == 2'b00);
    rxw_sel   = in_region && (off[13:12] == 2'b01);
    txw_sel   = in_region && (off[13:12] == 2'b10);
    wr        = i_we && in_region && (i_mem_size != 2'b11);
    unique case (i_mem_size)
      2'b00:   begin byte_en = 4'b1111; size_mask = 32'hFFFF_FFFF; end
      2'b01:   begin byte_en = 4'b0011; size_mask = 32'h0000_FFFF; end
      2'b10:   begin byte_en = 4'b0001; size_mask = 32'h0000_00FF; end
      default: begin byte_en = 4'b0000; size_mask = 32'h0; end
    endcase
    for (int k = 0; k < 4; k++) begin
      win_idx[k] = {1'b0, off[11:0]} + 13'(k);
      win_ok[k]  = byte_en[k] && (win_idx[k] < WinCap);
    end
  end

  logic ctrl_we, status_we, pop_we, txlen_we, trig_we, pop_ok;
  assign ctrl_we   = wr && reg_sel && (reg_word == 10'h0);
  assign status_we = wr && reg_sel && (reg_word == 10'h1);
  assign pop_we    = wr && reg_sel && (reg_word == 10'h5);
  assign txlen_we  = wr && reg_sel && (reg_word == 10'h6);
  assign trig_we   = wr && reg_sel && (reg_word == 10'h7);
  assign pop_ok    = pop_we && (rx_count_q != '0);

  logic [31:0] reg_rdata, win_rdata;
  always_comb begin
    reg_rdata = '0;
    case (reg_word)
      10'h0: reg_rdata = {30'b0, irq_en_q, rx_en_q};
      10'h1: reg_rdata = {27'b0, tx_done_q, ovf_q, tx_state_q == TxBusy,
                          rx_count_q == SlotsFull, rx_count_q != '0};
      10'h2: reg_rdata = 32'(rx_count_q);
      10'h3: reg_rdata = {15'b0, rx_trunc_q[rx_head_q], rx_len_q[rx_head_q]};
      10'h4: reg_rdata = {rx_src_q[rx_head_q], rx_dest_q[rx_head_q]};
      10'h6: reg_rdata = {16'b0, tx_len_q};
      10'h8: reg_rdata = {16'b0, drop_cnt_q};
      default: reg_rdata = '0;
    endcase
    win_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (win_ok[k] && rxw_sel) win_rdata[8*k +: 8] = rx_mem[{rx_head_q, win_idx[k][AW-1:0]}];
      else if (win_ok[k] && txw_sel) win_rdata[8*k +: 8] = tx_mem[win_idx[k][AW-1:0]];
    end
    o_data = reg_sel ? ((reg_rdata >> {off[1:0], 3'b000}) & size_mask) : win_rdata;
  end

  // RX byte-stream engine.
  logic          rx_we, commit, drop, commit_trunc;
  logic [AW-1:0] rx_waddr;
  logic [15:0]   commit_len;
  always_comb begin
    rx_state_d   = rx_state_q;
    wr_idx_d     = wr_idx_q;
    rx_we        = 1'b0;
    rx_waddr     = wr_idx_q[AW-1:0];
    commit       = 1'b0;
    commit_len   = 16'(wr_idx_q) + 16'd1;
    commit_trunc = 1'b0;
    drop         = 1'b0;
    unique case (rx_state_q)
      RxIdle: if (i_rx_valid) begin
        if (rx_en_q && (rx_count_q < SlotsFull)) begin
          rx_we      = 1'b1;
          rx_waddr   = '0;
          commit_len = 16'd1;
          commit     = i_rx_last && !i_rx_err;
          wr_idx_d   = (AW+1)'(1);
          if (!i_rx_last) rx_state_d = RxRecv;
        end else begin
          drop = 1'b1;
          if (!i_rx_last) rx_state_d = RxDrop;
        end
      end
      RxRecv: if (i_rx_valid) begin
        if (wr_idx_q < SlotCap) begin
          rx_we    = 1'b1;
          wr_idx_d = wr_idx_q + (AW+1)'(1);
        end else begin
          commit_len   = 16'(SLOT_BYTES);
          commit_trunc = 1'b1;
        end
        if (i_rx_last) begin
          commit     = !i_rx_err;
          rx_state_d = RxIdle;
        end
      end
      RxDrop: if (i_rx_valid && i_rx_last) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    rx_head_d  = pop_ok ? rx_head_q + SW'(1) : rx_head_q;
    rx_tail_d  = commit ? rx_tail_q + SW'(1) : rx_tail_q;
    rx_count_d = rx_count_q + (SW+1)'(commit) - (SW+1)'(pop_ok);
    rx_en_d    = ctrl_we ? i_data[0] : rx_en_q;
    irq_en_d   = ctrl_we ? i_data[1] : irq_en_q;
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    tx_state_d = tx_state_q;
    tx_start_d = 1'b0;
    tx_len_d   = (txlen_we && tx_state_q == TxIdle) ? i_data[15:0] : tx_len_q;
    tx_done_d  = tx_done_q && !(status_we && i_data[4]);
    ovf_d      = (ovf_q && !(status_we && i_data[3])) || drop;
    if (tx_state_q == TxIdle) begin
      if (trig_we && i_data[0] && tx_len_q != '0) begin
        tx_start_d = 1'b1;
        tx_state_d = TxBusy;
      end
    end else if (i_tx_done) begin
      tx_state_d = TxIdle;
      tx_done_d  = 1'b1;
    end
    irq_d = irq_en_q && ((rx_count_q != '0) || tx_done_q || ovf_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rx_state_q <= RxIdle;
      tx_state_q <= TxIdle;
      wr_idx_q   <= '0;
      rx_head_q  <= '0;
      rx_tail_q  <= '0;
      rx_count_q <= '0;
      rx_en_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_start_q <= 1'b0;
      irq_q      <= 1'b0;
      tx_len_q   <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < RX_SLOTS; i++) begin
        rx_len_q[i]   <= '0;
        rx_trunc_q[i] <= 1'b0;
        rx_src_q[i]   <= '0;
        rx_dest_q[i]  <= '0;
      end
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      wr_idx_q   <= wr_idx_d;
      rx_head_q  <= rx_head_d;
      rx_tail_q  <= rx_tail_d;
      rx_count_q <= rx_count_d;
      rx_en_q    <= rx_en_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      tx_done_q  <= tx_done_d;
      tx_start_q <= tx_start_d;
      irq_q      <= irq_d;
      tx_len_q   <= tx_len_d;
      drop_cnt_q <= drop_cnt_d;
      if (commit) begin
        rx_len_q[rx_tail_q]   <= commit_len;
        rx_trunc_q[rx_tail_q] <= commit_trunc;
        rx_src_q[rx_tail_q]   <= i_rx_src_port;
        rx_dest_q[rx_tail_q]  <= i_rx_dest_port;
      end
    end
  end

  // Buffer storage carries no reset.
  always_ff @(posedge i_clk) begin
    if (rx_we) rx_mem[{rx_tail_q, rx_waddr}] <= i_rx_data;
    for (int k = 0; k < 4; k++) begin
      if (wr && txw_sel && win_ok[k] && tx_state_q == TxIdle) begin
        tx_mem[win_idx[k][AW-1:0]] <= i_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) tx_rd_data_q <= '0;
    else         tx_rd_data_q <= tx_mem[i_tx_rd_addr];
  end

  assign o_tx_start   = tx_start_q;
  assign o_tx_length  = tx_len_q;
  assign o_tx_rd_data = tx_rd_data_q;
  assign o_irq        = irq_q;
endmodule

// File: tb/tb_eth_mmio_ring.sv
// Directed self-checking bench for eth_mmio_ring: RX ring, truncation, drop/overflow,
// commit+pop collisions, TX handshake and mid-operation reset.
module tb_eth_mmio_ring;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10;

  logic        i_clk = 1'b0;
  logic        i_rstn, i_we, i_re;
  logic [31:0] i_addr, i_data, o_data;
  logic [1:0]  i_mem_size;
  logic        o_irq, i_rx_valid, i_rx_last, i_rx_err, o_tx_start, i_tx_done;
  logic [7:0]  i_rx_data, o_tx_rd_data;
  logic [15:0] i_rx_src_port, i_rx_dest_port, o_tx_length;
  logic [9:0]  i_tx_rd_addr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] d;

  eth_mmio_ring dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_we(i_we), .i_re(i_re), .i_addr(i_addr),
    .i_data(i_data), .i_mem_size(i_mem_size), .o_data(o_data), .o_irq(o_irq),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .i_rx_last(i_rx_last),
    .i_rx_err(i_rx_err), .i_rx_src_port(i_rx_src_port), .i_rx_dest_port(i_rx_dest_port),
    .o_tx_start(o_tx_start), .o_tx_length(o_tx_length), .i_tx_rd_addr(i_tx_rd_addr),
    .o_tx_rd_data(o_tx_rd_data), .i_tx_done(i_tx_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] off, input logic [31:0] data, input logic [1:0] sz);
    @(negedge i_clk);
    i_addr = BASE + 32'(off); i_data = data; i_mem_size = sz; i_we = 1'b1;
    @(negedge i_clk);
    i_we = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [15:0] off, input logic [1:0] sz,
                      input logic [31:0] exp);
    logic [31:0] r;
    @(negedge i_clk);
    i_addr = BASE + 32'(off); i_mem_size = sz; i_re = 1'b1;
    #1 r = o_data;
    i_re = 1'b0;
    chk(tag, r, exp);
  endtask

  task automatic frame(input int len, input logic [7:0] start, input logic err,
                       input logic [15:0] src, input logic [15:0] dst, input logic pop_last);
    for (int i = 0; i < len; i++) begin
      @(negedge i_clk);
      i_rx_valid = 1'b1;
      i_rx_data  = start + 8'(i);
      i_rx_last  = (i == len - 1);
      i_rx_err   = (i == len - 1) && err;
      i_rx_src_port = src; i_rx_dest_port = dst;
      if (pop_last && i == len - 1) begin
        i_addr = BASE + 32'h14; i_mem_size = W; i_we = 1'b1;
      end
    end
    @(negedge i_clk);
    i_rx_valid = 1'b0; i_rx_last = 1'b0; i_rx_err = 1'b0; i_we = 1'b0;
  endtask

  initial begin
    i_rstn = 1'b0; i_we = 1'b0; i_re = 1'b0; i_addr = '0; i_data = '0; i_mem_size = W;
    i_rx_valid = 1'b0; i_rx_data = '0; i_rx_last = 1'b0; i_rx_err = 1'b0;
    i_rx_src_port = '0; i_rx_dest_port = '0; i_tx_rd_addr = '0; i_tx_done = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_tx_start", 32'(o_tx_start), 0);
    chk("rst_irq", 32'(o_irq), 0);
    chk("rst_tx_rd_data", 32'(o_tx_rd_data), 0);
    i_rstn = 1'b1;
    rchk("rst_status", 16'h04, W, 0);
    rchk("rst_count", 16'h08, W, 0);
    rchk("rst_ctrl", 16'h00, W, 0);
    rchk("rst_drop", 16'h20, W, 0);
    rchk("rst_txlen", 16'h18, W, 0);

    wr(16'h00, 32'h3, W);
    rchk("ctrl_rw", 16'h00, W, 32'h3);

    // 60-byte frame, ports 1234/80
    frame(60, 8'h00, 1'b0, 16'd1234, 16'd80, 1'b0);
    rchk("f1_count", 16'h08, W, 1);
    rchk("f1_len", 16'h0C, W, 60);
    rchk("f1_ports", 16'h10, W, 32'h04D2_0050);
    rchk("f1_word0", 16'h1000, W, 32'h0302_0100);
    rchk("f1_half2", 16'h1002, H, 32'h0000_0302);
    rchk("f1_byte59", 16'h103B, B, 32'h3B);
    rchk("f1_status", 16'h04, W, 32'h1);
    chk("f1_irq", 32'(o_irq), 1);

    // Fill the ring, then overflow
    frame(8, 8'h10, 1'b0, 16'd1, 16'd2, 1'b0);
    frame(8, 8'h20, 1'b0, 16'd1, 16'd2, 1'b0);
    frame(8, 8'h30, 1'b0, 16'd1, 16'd2, 1'b0);
    rchk("full_status", 16'h04, W, 32'h3);
    frame(8, 8'h40, 1'b0, 16'd1, 16'd2, 1'b0);
    rchk("ovf_status", 16'h04, W, 32'h0B);
    rchk("ovf_drop", 16'h20, W, 1);
    rchk("ovf_count", 16'h08, W, 4);
    wr(16'h04, 32'h08, W);
    rchk("ovf_w1c", 16'h04, W, 32'h3);

    wr(16'h14, 0, W);
    rchk("pop1_count", 16'h08, W, 3);
    rchk("pop1_len", 16'h0C, W, 8);
    rchk("pop1_word", 16'h1000, W, 32'h1312_1110);
    frame(5, 8'h60, 1'b0, 16'd7, 16'd9, 1'b0);
    rchk("wrap_count", 16'h08, W, 4);
    repeat (3) wr(16'h14, 0, W);
    rchk("wrap_len", 16'h0C, W, 5);
    rchk("wrap_ports", 16'h10, W, 32'h0007_0009);
    rchk("wrap_word", 16'h1000, W, 32'h6362_6160);
    wr(16'h14, 0, W);
    wr(16'h14, 0, W);
    rchk("pop_empty_count", 16'h08, W, 0);
    rchk("pop_empty_status", 16'h04, W, 0);

    // Truncation and error-on-last
    frame(1100, 8'h00, 1'b0, 16'd5, 16'd6, 1'b0);
    rchk("trunc_len", 16'h0C, W, 32'h0001_0400);
    rchk("trunc_last", 16'h13FF, B, 32'hFF);
    rchk("trunc_edge_word", 16'h13FE, W, 32'h0000_FFFE);
    frame(10, 8'h50, 1'b1, 16'd5, 16'd6, 1'b0);
    rchk("err_count", 16'h08, W, 1);
    rchk("err_drop", 16'h20, W, 1);

    // Commit and pop in the same cycle
    frame(4, 8'hA0, 1'b0, 16'd1, 16'd1, 1'b0);
    rchk("cp_pre_count", 16'h08, W, 2);
    frame(3, 8'hB0, 1'b0, 16'd1, 16'd1, 1'b1);
    rchk("cp_count", 16'h08, W, 2);
    rchk("cp_head_len", 16'h0C, W, 4);
    rchk("cp_head_word", 16'h1000, W, 32'hA3A2_A1A0);
    wr(16'h14, 0, W);
    rchk("cp_tail_len", 16'h0C, W, 3);
    rchk("cp_tail_half", 16'h1000, H, 32'hB1B0);
    rchk("cp_tail_byte", 16'h1002, B, 32'hB2);
    wr(16'h14, 0, W);
    rchk("cp_empty", 16'h04, W, 0);

    // TX path
    wr(16'h2000, 32'hDDCC_BBAA, W);
    wr(16'h2004, 32'h0000_0011, B);
    rchk("tx_win_word", 16'h2000, W, 32'hDDCC_BBAA);
    wr(16'h18, 64, W);
    rchk("tx_len", 16'h18, W, 64);
    chk("tx_irq_idle", 32'(o_irq), 0);
    wr(16'h1C, 1, W);
    chk("tx_start_pulse", 32'(o_tx_start), 1);
    chk("tx_length", 32'(o_tx_length), 64);
    @(negedge i_clk);
    chk("tx_start_end", 32'(o_tx_start), 0);
    rchk("tx_busy", 16'h04, W, 32'h4);
    wr(16'h1C, 1, W);
    chk("tx_retrig", 32'(o_tx_start), 0);
    wr(16'h18, 99, W);
    rchk("tx_len_locked", 16'h18, W, 64);
    wr(16'h2000, 32'h55, B);
    rchk("tx_win_locked", 16'h2000, B, 32'hAA);
    @(negedge i_clk); i_tx_rd_addr = 10'd4;
    @(negedge i_clk);
    chk("tx_rd4", 32'(o_tx_rd_data), 32'h11);
    i_tx_rd_addr = 10'd1;
    @(negedge i_clk);
    chk("tx_rd1", 32'(o_tx_rd_data), 32'hBB);
    i_tx_done = 1'b1;
    @(negedge i_clk); i_tx_done = 1'b0;
    rchk("tx_done", 16'h04, W, 32'h10);
    @(negedge i_clk);
    chk("tx_done_irq", 32'(o_irq), 1);
    wr(16'h04, 32'h10, W);
    rchk("tx_done_w1c", 16'h04, W, 0);
    @(negedge i_clk);
    chk("irq_cleared", 32'(o_irq), 0);

    // Reset in the middle of TX and an RX frame
    frame(4, 8'h70, 1'b0, 16'd1, 16'd1, 1'b0);
    wr(16'h1C, 1, W);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_rx_valid = 1'b1; i_rx_data = 8'(i); i_rx_last = 1'b0;
    end
    @(negedge i_clk);
    i_rstn = 1'b0; i_rx_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("mid_rst_tx_start", 32'(o_tx_start), 0);
    i_rstn = 1'b1;
    rchk("mid_rst_status", 16'h04, W, 0);
    rchk("mid_rst_count", 16'h08, W, 0);
    rchk("mid_rst_ctrl", 16'h00, W, 0);
    rchk("mid_rst_txlen", 16'h18, W, 0);
    frame(2, 8'h80, 1'b0, 16'd1, 16'd1, 1'b0);
    rchk("rxdis_status", 16'h04, W, 32'h08);
    rchk("rxdis_drop", 16'h20, W, 1);
    wr(16'h00, 32'h1, W);
    frame(4, 8'hC0, 1'b0, 16'd3, 16'd4, 1'b0);
    rchk("post_rst_count", 16'h08, W, 1);
    rchk("post_rst_word", 16'h1000, W, 32'hC3C2_C1C0);
    rchk("post_rst_len", 16'h0C, W, 4);
    chk("post_rst_irq", 32'(o_irq), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
